// File: rtl/two_sum_engine_if.sv
// Two-sum engine bus: problem control, element stream, hashmap ports and result.
//   slave  : engine side (receives start/stream/hashmap query result, drives the rest)
//   master : upstream/environment side (drives start/stream, owns the hashmap)
interface two_sum_engine_if #(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned INDEX_WIDTH = 4
);
    // problem control
    logic                   start;
    logic [DATA_WIDTH-1:0]  target;
    // element stream
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_data;
    logic                   in_last;
    // hashmap insert/query/clear
    logic [DATA_WIDTH-1:0]  hm_write_key;
    logic [INDEX_WIDTH-1:0] hm_write_value;
    logic                   hm_write_request;
    logic [DATA_WIDTH-1:0]  hm_read_key;
    logic [INDEX_WIDTH-1:0] hm_read_value;
    logic                   hm_read_response;
    logic                   hm_clear;
    // result
    logic                   done;
    logic                   found;
    logic                   overflow;
    logic [INDEX_WIDTH-1:0] index_a;
    logic [INDEX_WIDTH-1:0] index_b;

    modport slave (
        input  start, target, in_valid, in_data, in_last,
               hm_read_value, hm_read_response,
        output in_ready, hm_write_key, hm_write_value, hm_write_request,
               hm_read_key, hm_clear, done, found, overflow, index_a, index_b
    );

    modport master (
        output start, target, in_valid, in_data, in_last,
               hm_read_value, hm_read_response,
        input  in_ready, hm_write_key, hm_write_value, hm_write_request,
               hm_read_key, hm_clear, done, found, overflow, index_a, index_b
    );
endinterface

// File: rtl/two_sum_engine.sv
// Two-sum engine: streams an array, queries an external hashmap for the
// complement of each element before inserting it, and reports the first pair
// whose values sum (mod 2**DATA_WIDTH) to the target.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : two_sum_engine_if.slave (start/target, in_* stream, hm_* hashmap,
//          done/found/overflow/index_a/index_b result)
module two_sum_engine #(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned INDEX_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    two_sum_engine_if.slave    bus
);

    localparam int unsigned MAX_LEN = 2 ** INDEX_WIDTH;

    typedef enum logic [2:0] {IDLE, CLEAR, ACCEPT, LOOKUP, DONE} state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  target_q, target_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   last_q, last_d;
    logic                   in_ready_q, in_ready_d;
    logic                   done_q, done_d;
    logic                   found_q, found_d;
    logic                   overflow_q, overflow_d;
    logic [INDEX_WIDTH-1:0] index_a_q, index_a_d;
    logic [INDEX_WIDTH-1:0] index_b_q, index_b_d;
    logic                   hm_clear_q, hm_clear_d;
    logic                   hm_wreq_q, hm_wreq_d;
    logic [DATA_WIDTH-1:0]  hm_wkey_q, hm_wkey_d;
    logic [INDEX_WIDTH-1:0] hm_wval_q, hm_wval_d;
    logic [DATA_WIDTH-1:0]  hm_rkey_q, hm_rkey_d;

    logic [DATA_WIDTH-1:0]  elem_mem [MAX_LEN];
    logic                   mem_we_c;
    logic                   hit_c;

    // The hashmap may alias keys; only trust a response whose stored element
    // really completes the sum.
    always_comb begin
        hit_c = bus.hm_read_response &&
                (DATA_WIDTH'(elem_mem[bus.hm_read_value] + data_q) == target_q);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        idx_d      = idx_q;
        data_d     = data_q;
        last_d     = last_q;
        found_d    = found_q;
        overflow_d = overflow_q;
        index_a_d  = index_a_q;
        index_b_d  = index_b_q;
        hm_wkey_d  = hm_wkey_q;
        hm_wval_d  = hm_wval_q;
        hm_rkey_d  = hm_rkey_q;
        hm_wreq_d  = 1'b0;
        mem_we_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = CLEAR;
                    target_d   = bus.target;
                    idx_d      = '0;
                    found_d    = 1'b0;
                    overflow_d = 1'b0;
                    index_a_d  = '0;
                    index_b_d  = '0;
                end
            end
            CLEAR: begin
                state_d = ACCEPT;
            end
            ACCEPT: begin
                if (bus.in_valid) begin
                    data_d    = bus.in_data;
                    last_d    = bus.in_last;
                    hm_rkey_d = DATA_WIDTH'(target_q - bus.in_data);
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_c) begin
                    found_d   = 1'b1;
                    index_a_d = bus.hm_read_value;
                    index_b_d = idx_q;
                    state_d   = DONE;
                end else begin
                    // Insert after the query so an element never pairs with itself.
                    hm_wreq_d = 1'b1;
                    hm_wkey_d = data_q;
                    hm_wval_d = idx_q;
                    mem_we_c  = 1'b1;
                    idx_d     = idx_q + INDEX_WIDTH'(1);
                    if (last_q) begin
                        state_d = DONE;
                    end else if (idx_q == INDEX_WIDTH'(MAX_LEN - 1)) begin
                        overflow_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = ACCEPT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == ACCEPT);
        hm_clear_d = (state_d == CLEAR);
        done_d     = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            target_q   <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
            overflow_q <= 1'b0;
            index_a_q  <= '0;
            index_b_q  <= '0;
            hm_clear_q <= 1'b0;
            hm_wreq_q  <= 1'b0;
            hm_wkey_q  <= '0;
            hm_wval_q  <= '0;
            hm_rkey_q  <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            last_q     <= last_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            found_q    <= found_d;
            overflow_q <= overflow_d;
            index_a_q  <= index_a_d;
            index_b_q  <= index_b_d;
            hm_clear_q <= hm_clear_d;
            hm_wreq_q  <= hm_wreq_d;
            hm_wkey_q  <= hm_wkey_d;
            hm_wval_q  <= hm_wval_d;
            hm_rkey_q  <= hm_rkey_d;
        end
    end

    // Local copy of inserted elements, used to confirm hashmap hits.
    always_ff @(posedge clk) begin
        if (mem_we_c && !rst) begin
            elem_mem[idx_q] <= data_q;
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.done             = done_q;
    assign bus.found            = found_q;
    assign bus.overflow         = overflow_q;
    assign bus.index_a          = index_a_q;
    assign bus.index_b          = index_b_q;
    assign bus.hm_clear         = hm_clear_q;
    assign bus.hm_write_request = hm_wreq_q;
    assign bus.hm_write_key     = hm_wkey_q;
    assign bus.hm_write_value   = hm_wval_q;
    assign bus.hm_read_key      = hm_rkey_q;

endmodule

// File: tb/tb_two_sum_engine.sv
// Directed bench for two_sum_engine with a 4-entry aliasing hashmap model
// (slot = key mod 4, no key compare) and a result scoreboard.
module tb_two_sum_engine;

    typedef struct packed {
        logic       found;
        logic       overflow;
        logic [3:0] a;
        logic [3:0] b;
    } res_t;

    logic clk = 1'b0;
    logic rst;

    two_sum_engine_if #(.DATA_WIDTH(4), .INDEX_WIDTH(4)) bus ();

    two_sum_engine #(.DATA_WIDTH(4), .INDEX_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Hashmap model: CACHE_SIZE=4, combinational read, write/clear on clock.
    logic       hm_vld [4];
    logic [3:0] hm_val [4];

    always @(posedge clk) begin
        if (bus.hm_clear) begin
            for (int i = 0; i < 4; i++) hm_vld[i] <= 1'b0;
        end else if (bus.hm_write_request) begin
            hm_vld[bus.hm_write_key[1:0]] <= 1'b1;
            hm_val[bus.hm_write_key[1:0]] <= bus.hm_write_value;
        end
    end

    assign bus.hm_read_response = hm_vld[bus.hm_read_key[1:0]];
    assign bus.hm_read_value    = hm_val[bus.hm_read_key[1:0]];

    // Free-running counters, each with a single writer.
    int cyc      = 0;
    int wr_cnt   = 0;
    int clr_cnt  = 0;
    int both_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.hm_write_request) wr_cnt <= wr_cnt + 1;
        if (bus.hm_clear) clr_cnt <= clr_cnt + 1;
        if (bus.hm_write_request && bus.hm_clear) both_cnt <= both_cnt + 1;
    end

    int         checks    = 0;
    int         errors    = 0;
    int         done_seen = 0;
    int         done_cyc  = 0;
    int         xfer_cyc  = 0;
    string      cur_tag   = "reset";
    res_t       exp_q [$];
    logic [3:0] stim_q [$];

    function automatic res_t mk(input logic f, input logic o,
                                input logic [3:0] a, input logic [3:0] b);
        mk = {f, o, a, b};
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any result strobe there.
    task automatic tick();
        res_t e;
        @(negedge clk);
        if (bus.done === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
            check({cur_tag, "_pending"}, exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({cur_tag, "_found"},    int'(bus.found),    int'(e.found));
                check({cur_tag, "_overflow"}, int'(bus.overflow), int'(e.overflow));
                check({cur_tag, "_index_a"},  int'(bus.index_a),  int'(e.a));
                check({cur_tag, "_index_b"},  int'(bus.index_b),  int'(e.b));
            end
        end
    endtask

    // Offer one element; report whether it was transferred within a bounded wait.
    task automatic send_elem(input logic [3:0] d, input bit l, output bit taken);
        int c;
        c = 0;
        taken = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!taken && c < 12) begin
            if (bus.in_ready === 1'b1) begin
                taken = 1'b1;
                xfer_cyc = cyc;
            end
            tick();
            c++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic run_problem(input string tag, input logic [3:0] tgt, input bit mark_last,
                               input res_t exp, input int exp_taken);
        int n;
        int w;
        int base_done;
        int first_xfer;
        bit tk;
        n = 0;
        first_xfer = 0;
        cur_tag = tag;
        base_done = done_seen;
        exp_q.push_back(exp);
        bus.start  = 1'b1;
        bus.target = tgt;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < stim_q.size(); i++) begin
            send_elem(stim_q[i], mark_last && (i == stim_q.size() - 1), tk);
            if (!tk) break;
            if (n == 0) first_xfer = xfer_cyc;
            n++;
        end
        w = 0;
        while (done_seen == base_done && w < 100) begin
            tick();
            w++;
        end
        check({tag, "_done_count"}, done_seen - base_done, 1);
        if (done_seen == base_done && exp_q.size() > 0) void'(exp_q.pop_back());
        check({tag, "_consumed"}, n, exp_taken);
        check({tag, "_latency"}, done_cyc - xfer_cyc, 2);
        check({tag, "_throughput"}, xfer_cyc - first_xfer, 2 * (n - 1));
        tick();
        tick();
        check({tag, "_in_ready_idle"}, int'(bus.in_ready), 0);
        check({tag, "_done_pulse"}, int'(bus.done), 0);
    endtask

    initial begin
        int base_wr;
        int base_clr;
        bit tk;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.target   = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (3) tick();

        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_found", int'(bus.found), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        check("rst_hm_write_request", int'(bus.hm_write_request), 0);
        check("rst_hm_clear", int'(bus.hm_clear), 0);
        check("rst_index_a", int'(bus.index_a), 0);
        check("rst_index_b", int'(bus.index_b), 0);
        rst = 1'b0;
        tick();

        // Early hit: 11 and 15 must stay unconsumed.
        stim_q = '{4'd2, 4'd7, 4'd11, 4'd15};
        run_problem("basic", 4'd9, 1'b1, mk(1'b1, 1'b0, 4'd0, 4'd1), 2);

        // Duplicate values pair with each other, not themselves.
        stim_q = '{4'd3, 4'd3};
        run_problem("dup", 4'd6, 1'b1, mk(1'b1, 1'b0, 4'd0, 4'd1), 2);

        // No solution: every element inserted.
        base_wr = wr_cnt;
        stim_q = '{4'd1, 4'd2, 4'd3};
        run_problem("nosol", 4'd15, 1'b1, mk(1'b0, 1'b0, 4'd0, 4'd0), 3);
        check("nosol_writes", wr_cnt - base_wr, 3);

        // Aliased hashmap response must be rejected.
        stim_q = '{4'd5, 4'd3};
        run_problem("collision", 4'd4, 1'b1, mk(1'b0, 1'b0, 4'd0, 4'd0), 2);

        // 9 + 9 wraps to 2.
        stim_q = '{4'd9, 4'd9};
        run_problem("wrap", 4'd2, 1'b1, mk(1'b1, 1'b0, 4'd0, 4'd1), 2);

        // Sixteen elements without last overflow the index space.
        stim_q.delete();
        for (int i = 0; i < 16; i++) stim_q.push_back(4'd0);
        run_problem("overflow", 4'd1, 1'b0, mk(1'b0, 1'b1, 4'd0, 4'd0), 16);
        repeat (3) tick();
        check("overflow_hold", int'(bus.overflow), 1);

        // Abort mid-problem after 7 is stored at index 0 (hashmap key 7, slot 3).
        cur_tag = "abort";
        bus.start  = 1'b1;
        bus.target = 4'd0;
        tick();
        bus.start = 1'b0;
        send_elem(4'd7, 1'b0, tk);
        check("abort_taken", int'(tk), 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("abort_rst_in_ready", int'(bus.in_ready), 0);
        check("abort_rst_overflow", int'(bus.overflow), 0);
        check("abort_rst_found", int'(bus.found), 0);
        check("abort_rst_done", int'(bus.done), 0);
        rst = 1'b0;
        tick();

        // A stale entry would make 2 falsely pair with the aborted 7 at (0,0).
        base_clr = clr_cnt;
        stim_q = '{4'd2, 4'd7};
        run_problem("restart", 4'd9, 1'b1, mk(1'b1, 1'b0, 4'd0, 4'd1), 2);
        check("restart_clear_cycles", clr_cnt - base_clr, 1);

        check("write_clear_overlap", both_cnt, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
